rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_pkg.sv | 26 ++
 rtl/rr_arbiter4_if.sv | 13 +
 rtl/dec2x4.sv | 11 +
 rtl/rr_arbiter4.sv | 79 +++++++
 tb/tb_rr_arbiter4.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// default hold limit and the rotating priority search.
package rr_pkg;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned ID_W         = 2;
  localparam int unsigned HOLD_W       = 4;
  localparam int unsigned HOLD_MAX_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First requester found scanning ptr, ptr+1, ... (mod 4); returns ptr if none.
  function automatic logic [ID_W-1:0] rr_pick(input logic [0:N_REQ-1] req,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the arbiter.
interface rr_arbiter4_if;
  import rr_pkg::*;

  logic [0:N_REQ-1] req;
  logic             done;
  logic [0:N_REQ-1] gnt;
  logic [0:ID_W-1]  gnt_id;
  logic             busy;

  modport master (output req, output done, input gnt, input gnt_id, input busy);
  modport slave  (input req, input done, output gnt, output gnt_id, output busy);
endinterface

// File: rtl/dec2x4.sv
// 2-to-4 one-hot decoder with enable; output index i is set when sel == i.
module dec2x4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [0:3] y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time and a mandatory
// idle bubble between grants.
module rr_arbiter4
  import rr_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              release_c;
  logic              busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
    end
  end

  // Owner is only re-chosen from IDLE, so other req bits cannot disturb a grant.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    hold_d    = hold_q;
    release_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          id_d    = rr_pick(bus.req, ptr_q);
          hold_d  = HOLD_ONE;
        end
      end
      GRANT: begin
        release_c = bus.done || !bus.req[id_q] || (hold_q == HOLD_LIM);
        if (release_c) begin
          state_d = IDLE;
          ptr_d   = id_q + ID_W'(1);
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_c     = (state_q == GRANT);
  assign bus.busy   = busy_c;
  assign bus.gnt_id = id_q;

  dec2x4 u_dec (
    .sel (id_q),
    .en  (busy_c),
    .y   (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and random checks of rr_arbiter4 against an arithmetic reference model.
module tb_rr_arbiter4;
  import rr_pkg::*;

  localparam int HOLD = int'(HOLD_MAX_DEF);

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // Reference model state: owner index, rotation start, cycles held so far.
  int   m_busy;
  int   m_id;
  int   m_ptr;
  int   m_held;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(HOLD_MAX_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [0:3] rq, input logic d);
    if (r) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_held = 0;
    end else if (m_busy == 0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (rq[i]) begin
          m_busy = 1; m_id = i; m_held = 1;
          break;
        end
      end
    end else if (d || !rq[m_id] || m_held >= HOLD) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % 4;
    end else begin
      m_held = m_held + 1;
    end
  endtask

  // Apply inputs, clock one edge, then compare all outputs with the model.
  task automatic tick(input logic r, input logic [0:3] rq, input logic d);
    logic [0:3] eg;
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    @(posedge clk);
    model_step(r, rq, d);
    #1;
    eg = '0;
    if (m_busy != 0) eg[m_id] = 1'b1;
    chk("gnt",    32'(bus.gnt),    32'(eg));
    chk("gnt_id", 32'(bus.gnt_id), 32'(m_id));
    chk("busy",   32'(bus.busy),   32'(m_busy));
  endtask

  initial begin
    logic [0:3] order [9];
    errors = 0; checks = 0;
    m_busy = 0; m_id = 0; m_ptr = 0; m_held = 0;
    rst = 1'b1; bus.req = '0; bus.done = 1'b0;

    // Reset with every request asserted.
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 4'b1111, 1'b0);
      chk("rst_gnt",    32'(bus.gnt),    32'h0);
      chk("rst_busy",   32'(bus.busy),   32'h0);
      chk("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    end

    // Single requester 2, one-cycle latency, released by done.
    tick(1'b0, 4'b0010, 1'b0);
    chk("lat_gnt",    32'(bus.gnt),    32'h2);
    chk("lat_gnt_id", 32'(bus.gnt_id), 32'h2);
    chk("lat_busy",   32'(bus.busy),   32'h1);
    tick(1'b0, 4'b0010, 1'b0);
    tick(1'b0, 4'b0010, 1'b1);
    chk("done_gnt", 32'(bus.gnt), 32'h0);
    tick(1'b0, 4'b1111, 1'b0);
    chk("ptr3_gnt", 32'(bus.gnt), 32'h1);
    tick(1'b0, 4'b1111, 1'b1);

    // All requesting with done held high: rotation with bubbles, done ignored in IDLE.
    order = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
              4'b0000, 4'b0001, 4'b0000, 4'b1000};
    for (int s = 0; s < 9; s++) begin
      tick(1'b0, 4'b1111, 1'b1);
      chk($sformatf("rot%0d", s), 32'(bus.gnt), 32'(order[s]));
    end
    tick(1'b0, 4'b0000, 1'b0);

    // Hold limit: eight grant cycles, one bubble, regrant.
    for (int s = 0; s < HOLD; s++) begin
      tick(1'b0, 4'b0010, 1'b0);
      chk($sformatf("hold%0d", s), 32'(bus.gnt), 32'h2);
    end
    tick(1'b0, 4'b0010, 1'b0);
    chk("hold_bubble", 32'(bus.gnt), 32'h0);
    tick(1'b0, 4'b0010, 1'b0);
    chk("hold_regrant", 32'(bus.gnt), 32'h2);
    tick(1'b0, 4'b0000, 1'b0);

    // Requester 1 drops req and asserts done together: one release, ptr -> 2.
    tick(1'b0, 4'b0100, 1'b0);
    chk("own1_gnt", 32'(bus.gnt), 32'h4);
    tick(1'b0, 4'b0000, 1'b1);
    chk("dual_busy", 32'(bus.busy), 32'h0);
    tick(1'b0, 4'b0110, 1'b0);
    chk("ptr2_gnt", 32'(bus.gnt), 32'h2);
    tick(1'b0, 4'b0000, 1'b0);

    // Reset during requester 3's grant restores priority to requester 0.
    tick(1'b0, 4'b0001, 1'b0);
    chk("own3_gnt", 32'(bus.gnt), 32'h1);
    tick(1'b1, 4'b0001, 1'b0);
    chk("midrst_gnt",  32'(bus.gnt),  32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    tick(1'b0, 4'b1001, 1'b0);
    chk("postrst_gnt", 32'(bus.gnt), 32'h8);
    tick(1'b0, 4'b0000, 1'b0);

    // Random traffic against the model.
    for (int s = 0; s < 400; s++) begin
      tick(($urandom_range(0, 49) == 0),
           4'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
